cw_rx_decoder: RTL

Morse (CW) receive-side decoder, the counterpart of the beacon keyer. It samples a one-bit keying input from an external envelope detector or key, deglitches it and times marks and spaces in dot units. It classifies each mark as dot or dash, assembles elements into a symbol code, and flags letter and word boundaries. Its outputs feed a character lookup / display stage downstream.

---
 rtl/cw_pkg.sv | 20 ++
 rtl/cw_key_filter.sv | 44 ++++
 rtl/cw_rx_decoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cw_pkg.sv
// Shared constants for the CW receive decoder: FSM encoding, timing thresholds
// in dot units and the element encoding used in sym_code.
package cw_pkg;
  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t MARK  = 3'd1;
  localparam state_t GAP   = 3'd2;
  localparam state_t LGAP  = 3'd3;
  localparam state_t STUCK = 3'd4;

  localparam int DASH_UNITS   = 2;
  localparam int LETTER_UNITS = 2;
  localparam int WORD_UNITS   = 5;
  localparam int STUCK_UNITS  = 8;
  localparam int MAX_ELEMS    = 6;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;
endpackage

// File: rtl/cw_key_filter.sv
// Key input conditioning: 2-flop synchronizer, prescaler tick and a tick-based
// deglitch filter that delays both edges equally.
module cw_key_filter #(
  parameter int CLK_DIV    = 65536,
  parameter int FILT_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_filt,
  output logic tick
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = $clog2(FILT_TICKS + 1);

  logic [1:0]    sync;
  logic [PW-1:0] pcnt;
  logic [FW-1:0] fcnt;

  assign tick = (pcnt == PW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync     <= '0;
      pcnt     <= '0;
      fcnt     <= '0;
      key_filt <= 1'b0;
    end else begin
      sync <= {sync[0], key_in};
      pcnt <= tick ? '0 : pcnt + PW'(1);
      // a new level is only accepted once it has been seen on FILT_TICKS ticks in a row
      if (tick) begin
        if (sync[1] == key_filt) begin
          fcnt <= '0;
        end else if (fcnt == FW'(FILT_TICKS - 1)) begin
          fcnt     <= '0;
          key_filt <= sync[1];
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/cw_rx_decoder.sv
// CW receive decoder: times filtered marks/spaces in ticks, classifies dots and
// dashes, assembles symbols and flags letter, word and stuck-key events.
module cw_rx_decoder
  import cw_pkg::*;
#(
  parameter int CLK_DIV    = 65536,
  parameter int UNIT_TICKS = 64,
  parameter int FILT_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       key_filt,
  output logic       sym_valid,
  output logic [5:0] sym_code,
  output logic [2:0] sym_len,
  output logic       sym_err,
  output logic       word_gap,
  output logic       stuck_err
);
  localparam int CMAX = STUCK_UNITS * UNIT_TICKS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CNT_MAX    = CW'(CMAX);
  localparam logic [CW-1:0] DASH_T     = CW'(DASH_UNITS * UNIT_TICKS);
  localparam logic [CW-1:0] LET_LAST   = CW'(LETTER_UNITS * UNIT_TICKS - 1);
  localparam logic [CW-1:0] WORD_LAST  = CW'(WORD_UNITS * UNIT_TICKS - 1);
  localparam logic [CW-1:0] STUCK_LAST = CW'(CMAX - 1);
  localparam logic [2:0]    LEN_MAX    = 3'(MAX_ELEMS);

  logic          tick, kf_q, rise, fall, elem;
  logic [CW-1:0] cnt;
  state_t        state;
  logic [5:0]    buf_code;
  logic [2:0]    buf_len;
  logic          ovf;

  cw_key_filter #(.CLK_DIV(CLK_DIV), .FILT_TICKS(FILT_TICKS)) u_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_filt (key_filt),
    .tick     (tick)
  );

  assign rise = key_filt & ~kf_q;
  assign fall = ~key_filt & kf_q;
  assign elem = (cnt >= DASH_T) ? DASH : DOT;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kf_q      <= 1'b0;
      cnt       <= '0;
      state     <= IDLE;
      buf_code  <= '0;
      buf_len   <= '0;
      ovf       <= 1'b0;
      sym_valid <= 1'b0;
      sym_code  <= '0;
      sym_len   <= '0;
      sym_err   <= 1'b0;
      word_gap  <= 1'b0;
      stuck_err <= 1'b0;
    end else begin
      kf_q      <= key_filt;
      sym_valid <= 1'b0;
      word_gap  <= 1'b0;
      stuck_err <= 1'b0;

      if (rise || fall)                  cnt <= '0;
      else if (tick && cnt != CNT_MAX)   cnt <= cnt + CW'(1);

      case (state)
        IDLE: if (rise) state <= MARK;
        MARK: begin
          // threshold tick wins over a coincident fall; the fall then ends STUCK at once
          if (tick && cnt == STUCK_LAST) begin
            stuck_err <= 1'b1;
            buf_code  <= '0;
            buf_len   <= '0;
            ovf       <= 1'b0;
            state     <= fall ? IDLE : STUCK;
          end else if (fall) begin
            if (buf_len < LEN_MAX) begin
              buf_code[buf_len] <= elem;
              buf_len           <= buf_len + 3'd1;
            end else begin
              ovf <= 1'b1;
            end
            state <= GAP;
          end
        end
        GAP: begin
          if (tick && cnt == LET_LAST) begin
            sym_valid <= 1'b1;
            sym_code  <= buf_code;
            sym_len   <= buf_len;
            sym_err   <= ovf;
            buf_code  <= '0;
            buf_len   <= '0;
            ovf       <= 1'b0;
            state     <= rise ? MARK : LGAP;
          end else if (rise) begin
            state <= MARK;
          end
        end
        LGAP: begin
          if (tick && cnt == WORD_LAST) begin
            word_gap <= 1'b1;
            state    <= rise ? MARK : IDLE;
          end else if (rise) begin
            state <= MARK;
          end
        end
        STUCK:   if (fall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
